// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the write-back value (ALU, load data, lwl/lwr merge, link)
// and presents registered GPR write controls plus a retired-instruction counter.
module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic             m_wen,
    input  logic [4:0]       m_wreg,
    input  logic [2:0]       m_ld_type,
    input  logic [1:0]       m_addr_lo,
    input  logic [31:0]      m_mem_rdata,
    input  logic [31:0]      m_alu_res,
    input  logic [31:0]      m_rt_val,
    input  logic [31:0]      m_pc,
    output logic             w_valid,
    output logic             w_wen,
    output logic [4:0]       w_wreg,
    output logic [31:0]      w_wdata,
    output logic [31:0]      w_pc,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [2:0] LD_ALU  = 3'd0;
    localparam logic [2:0] LD_MEM  = 3'd1;
    localparam logic [2:0] LD_LWL  = 3'd2;
    localparam logic [2:0] LD_LWR  = 3'd3;
    localparam logic [2:0] LD_LINK = 3'd4;

    // Unaligned-load merge: lwl fills the high bytes from memory, lwr the low bytes;
    // the bytes not covered keep the old rt value.
    function automatic logic [31:0] merge_wdata(
        input logic [2:0]  ld_type,
        input logic [1:0]  k,
        input logic [31:0] mem,
        input logic [31:0] alu,
        input logic [31:0] rt,
        input logic [31:0] pc
    );
        logic [31:0] res;
        res = alu;
        case (ld_type)
            LD_MEM:  res = mem;
            LD_LINK: res = pc + 32'd8;
            LD_LWL: begin
                case (k)
                    2'd0:    res = {mem[7:0],  rt[23:0]};
                    2'd1:    res = {mem[15:0], rt[15:0]};
                    2'd2:    res = {mem[23:0], rt[7:0]};
                    default: res = mem;
                endcase
            end
            LD_LWR: begin
                case (k)
                    2'd0:    res = mem;
                    2'd1:    res = {rt[31:24], mem[31:8]};
                    2'd2:    res = {rt[31:16], mem[31:16]};
                    default: res = {rt[31:8],  mem[31:24]};
                endcase
            end
            default: res = alu;
        endcase
        return res;
    endfunction

    logic             valid_q, valid_d;
    logic             wen_q,   wen_d;
    logic [4:0]       wreg_q,  wreg_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      pc_q,    pc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        valid_d = valid_q;
        wen_d   = wen_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            wen_d   = 1'b0;
            wreg_d  = 5'd0;
            wdata_d = 32'd0;
            pc_d    = 32'd0;
        end else if (!stall) begin
            valid_d = m_valid;
            // $0 is hardwired to zero, so a write to it is squashed here.
            wen_d   = m_valid & m_wen & (m_wreg != 5'd0);
            wreg_d  = m_wreg;
            wdata_d = merge_wdata(m_ld_type, m_addr_lo, m_mem_rdata,
                                  m_alu_res, m_rt_val, m_pc);
            pc_d    = m_pc;
            if (m_valid) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            wreg_q  <= 5'd0;
            wdata_q <= 32'd0;
            pc_q    <= 32'd0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign w_valid    = valid_q;
    assign w_wen      = wen_q;
    assign w_wreg     = wreg_q;
    assign w_wdata    = wdata_q;
    assign w_pc       = pc_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vectors, corner sequences and
// randomized traffic against a behavioural model.
module tb_mem_wb_stage;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, stall, flush, m_valid, m_wen;
    logic [4:0]       m_wreg;
    logic [2:0]       m_ld_type;
    logic [1:0]       m_addr_lo;
    logic [31:0]      m_mem_rdata, m_alu_res, m_rt_val, m_pc;
    logic             w_valid, w_wen;
    logic [4:0]       w_wreg;
    logic [31:0]      w_wdata, w_pc;
    logic [CNT_W-1:0] retire_cnt;

    mem_wb_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_wen(m_wen), .m_wreg(m_wreg),
        .m_ld_type(m_ld_type), .m_addr_lo(m_addr_lo),
        .m_mem_rdata(m_mem_rdata), .m_alu_res(m_alu_res),
        .m_rt_val(m_rt_val), .m_pc(m_pc),
        .w_valid(w_valid), .w_wen(w_wen), .w_wreg(w_wreg),
        .w_wdata(w_wdata), .w_pc(w_pc), .retire_cnt(retire_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic        e_valid, e_wen;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata, e_pc;
    int          e_cnt;

    function automatic logic [31:0] ref_merge(input logic [2:0] t, input logic [1:0] k,
                                              input logic [31:0] mem, input logic [31:0] alu,
                                              input logic [31:0] rt, input logic [31:0] pc);
        int sh;
        logic [31:0] keep;
        case (t)
            3'd1: return mem;
            3'd4: return pc + 32'd8;
            3'd2: begin
                sh = 8 * (3 - int'(k));
                keep = (sh == 0) ? 32'd0 : ((32'd1 << sh) - 32'd1);
                return (mem << sh) | (rt & keep);
            end
            3'd3: begin
                sh = 8 * int'(k);
                keep = ~(32'hFFFF_FFFF >> sh);
                return (mem >> sh) | (rt & keep);
            end
            default: return alu;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one clock, updating the model from the current inputs, then compare all outputs.
    task automatic tick(input string nm);
        if (reset) begin
            e_valid = 0; e_wen = 0; e_wreg = 0; e_wdata = 0; e_pc = 0; e_cnt = 0;
        end else if (flush) begin
            e_valid = 0; e_wen = 0; e_wreg = 0; e_wdata = 0; e_pc = 0;
        end else if (!stall) begin
            e_valid = m_valid;
            e_wen   = m_valid && m_wen && (m_wreg != 0);
            e_wreg  = m_wreg;
            e_wdata = ref_merge(m_ld_type, m_addr_lo, m_mem_rdata, m_alu_res, m_rt_val, m_pc);
            e_pc    = m_pc;
            if (m_valid) e_cnt = (e_cnt + 1) % (1 << CNT_W);
        end
        @(posedge clk);
        #1;
        chk({nm, ".valid"}, 32'(w_valid), 32'(e_valid));
        chk({nm, ".wen"},   32'(w_wen),   32'(e_wen));
        chk({nm, ".wreg"},  32'(w_wreg),  32'(e_wreg));
        chk({nm, ".wdata"}, w_wdata,      e_wdata);
        chk({nm, ".pc"},    w_pc,         e_pc);
        chk({nm, ".cnt"},   32'(retire_cnt), 32'(e_cnt));
    endtask

    task automatic randomize_fields();
        m_valid     = 1'($urandom);
        m_wen       = 1'($urandom);
        m_wreg      = 5'($urandom);
        m_ld_type   = 3'($urandom);
        m_addr_lo   = 2'($urandom);
        m_mem_rdata = $urandom;
        m_alu_res   = $urandom;
        m_rt_val    = $urandom;
        m_pc        = $urandom;
    endtask

    typedef struct {
        logic        valid;
        logic        wen;
        logic [4:0]  wreg;
        logic [2:0]  ld_type;
        logic [1:0]  k;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] pc;
        logic [31:0] exp_wdata;
        logic        exp_wen;
    } vec_t;

    vec_t vecs[10];

    logic [31:0] held_wdata, held_pc;
    logic [4:0]  held_wreg;
    logic        held_valid, held_wen;
    logic [CNT_W-1:0] held_cnt;

    initial begin
        vecs[0] = '{1, 1, 5'd3, 3'd2, 2'd0, 32'hAABBCCDD, 32'h0, 32'h11223344, 32'h100, 32'hDD223344, 1};
        vecs[1] = '{1, 1, 5'd3, 3'd2, 2'd1, 32'hAABBCCDD, 32'h0, 32'h11223344, 32'h104, 32'hCCDD3344, 1};
        vecs[2] = '{1, 1, 5'd3, 3'd2, 2'd2, 32'hAABBCCDD, 32'h0, 32'h11223344, 32'h108, 32'hBBCCDD44, 1};
        vecs[3] = '{1, 1, 5'd3, 3'd2, 2'd3, 32'hAABBCCDD, 32'h0, 32'h11223344, 32'h10C, 32'hAABBCCDD, 1};
        vecs[4] = '{1, 1, 5'd4, 3'd3, 2'd0, 32'hAABBCCDD, 32'h0, 32'h11223344, 32'h110, 32'hAABBCCDD, 1};
        vecs[5] = '{1, 1, 5'd4, 3'd3, 2'd1, 32'hAABBCCDD, 32'h0, 32'h11223344, 32'h114, 32'h11AABBCC, 1};
        vecs[6] = '{1, 1, 5'd4, 3'd3, 2'd2, 32'hAABBCCDD, 32'h0, 32'h11223344, 32'h118, 32'h1122AABB, 1};
        vecs[7] = '{1, 1, 5'd4, 3'd3, 2'd3, 32'hAABBCCDD, 32'h0, 32'h11223344, 32'h11C, 32'h112233AA, 1};
        vecs[8] = '{1, 1, 5'd31, 3'd4, 2'd0, 32'h0, 32'hDEAD, 32'h0, 32'h00003000, 32'h00003008, 1};
        vecs[9] = '{1, 1, 5'd0, 3'd0, 2'd0, 32'h0, 32'hCAFEF00D, 32'h0, 32'h200, 32'hCAFEF00D, 0};

        e_valid = 0; e_wen = 0; e_wreg = 0; e_wdata = 0; e_pc = 0; e_cnt = 0;

        // Reset dominates stall and flush
        reset = 1; stall = 1; flush = 1;
        randomize_fields();
        m_valid = 1;
        tick("reset");
        chk("reset.wdata_zero", w_wdata, 32'h0);
        chk("reset.cnt_zero", 32'(retire_cnt), 32'h0);

        // First load after release
        reset = 0; stall = 0; flush = 0;
        m_valid = 1; m_wen = 1; m_wreg = 5'd8; m_ld_type = 3'd0; m_alu_res = 32'h12345678;
        tick("first_load");
        chk("first_load.wdata_c", w_wdata, 32'h12345678);
        chk("first_load.wen_c", 32'(w_wen), 32'h1);
        chk("first_load.wreg_c", 32'(w_wreg), 32'd8);
        chk("first_load.cnt_c", 32'(retire_cnt), 32'd1);

        // Directed merge/link/$0 vectors
        for (int i = 0; i < 10; i++) begin
            m_valid = vecs[i].valid; m_wen = vecs[i].wen; m_wreg = vecs[i].wreg;
            m_ld_type = vecs[i].ld_type; m_addr_lo = vecs[i].k; m_mem_rdata = vecs[i].mem;
            m_alu_res = vecs[i].alu; m_rt_val = vecs[i].rt; m_pc = vecs[i].pc;
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.wdata_c", i), w_wdata, vecs[i].exp_wdata);
            chk($sformatf("vec%0d.wen_c", i), 32'(w_wen), 32'(vecs[i].exp_wen));
        end

        // Stall for 3 cycles with changing inputs: everything frozen
        held_valid = w_valid; held_wen = w_wen; held_wreg = w_wreg;
        held_wdata = w_wdata; held_pc = w_pc; held_cnt = retire_cnt;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_fields();
            m_valid = 1;
            tick($sformatf("stall%0d", i));
            chk($sformatf("stall%0d.wdata_h", i), w_wdata, held_wdata);
            chk($sformatf("stall%0d.pc_h", i), w_pc, held_pc);
            chk($sformatf("stall%0d.wreg_h", i), 32'(w_wreg), 32'(held_wreg));
            chk($sformatf("stall%0d.valid_h", i), 32'(w_valid), 32'(held_valid));
            chk($sformatf("stall%0d.wen_h", i), 32'(w_wen), 32'(held_wen));
            chk($sformatf("stall%0d.cnt_h", i), 32'(retire_cnt), 32'(held_cnt));
        end

        // Stall and flush together: bubble, counter unchanged
        flush = 1; m_valid = 1;
        tick("stall_flush");
        chk("stall_flush.valid_c", 32'(w_valid), 32'h0);
        chk("stall_flush.wen_c", 32'(w_wen), 32'h0);
        chk("stall_flush.cnt_c", 32'(retire_cnt), 32'(held_cnt));
        stall = 0; flush = 0;

        // Counter wrap: 16 valid loads interleaved with invalid ones
        reset = 1;
        tick("wrap_reset");
        reset = 0;
        for (int i = 0; i < 32; i++) begin
            randomize_fields();
            m_valid = (i % 2 == 0);
            tick($sformatf("wrap%0d", i));
            if (i == 29) chk("wrap.cnt15", 32'(retire_cnt), 32'd15);
        end
        chk("wrap.cnt0", 32'(retire_cnt), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomize_fields();
            reset = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
